flash_loader: RTL
=================

FLASH_LOADER -- requirements
Module: flash_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, flash word-address width (32768 words).
REQ-002 SHALL have parameter TIMEOUT, default 1000000, idle clock cycles allowed between accepted bytes before abort.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that arms a programming session.
REQ-006 SHALL have port rx_data  input  8  byte from the serial receiver.
REQ-007 SHALL have port rx_valid  input  1  rx_data valid this cycle.
REQ-008 SHALL have port rx_ready  output  1  loader accepts a byte this cycle; a byte transfers when rx_valid and rx_ready are both 1.
REQ-009 SHALL have port flash_addr  output  ADDR_W  flash write-port word address.
REQ-010 SHALL have port flash_din  output  32  flash write-port data.
REQ-011 SHALL have port flash_we  output  1  flash write enable, one cycle per word.
REQ-012 SHALL have port busy  output  1  session in progress.
REQ-013 SHALL have port done  output  1  last session completed.
REQ-014 SHALL have port err  output  1  last session aborted on timeout.
REQ-015 SHALL have port cpu_rst_n  output  1  active-low hold-in-reset for the core fetching from flash.

Function
REQ-016 SHALL implement states IDLE, LEN0, LEN1, DATA, WRITE, DONE, ERR.
REQ-017 IDLE/DONE/ERR: start=1 -> LEN0; clear byte index, word address, timeout counter, done, err. start SHALL be ignored in all other states.
REQ-018 LEN0: accepted byte -> length[7:0], go to LEN1. LEN1: accepted byte -> length[14:8] from rx_data[6:0]; rx_data[7] ignored.
REQ-019 On LEN1 accept with length 0, SHALL go to DONE with no flash writes; otherwise go to DATA.
REQ-020 DATA: accepted bytes assemble little-endian: byte 0 -> bits 7:0, byte 1 -> 15:8, byte 2 -> 23:16, byte 3 -> 31:24; the 4th accept goes to WRITE.
REQ-021 WRITE: exactly one cycle, flash_we=1, flash_addr=current word address, flash_din=assembled word; rx_ready=0.
REQ-022 After WRITE, word address SHALL increment; if the incremented count equals length go to DONE, else go to DATA with byte index 0.
REQ-023 rx_ready SHALL be 1 only in LEN0, LEN1, DATA; bytes offered in any other state are not consumed.
REQ-024 flash_addr and flash_din SHALL be registered and stable throughout WRITE; flash_we SHALL be 0 outside WRITE.
REQ-025 Timeout counter SHALL run in LEN0, LEN1, DATA; clear on every accepted byte; on reaching TIMEOUT -> ERR. Counter SHALL hold in WRITE.
REQ-026 busy SHALL be 1 in LEN0, LEN1, DATA, WRITE, else 0.
REQ-027 done SHALL be 1 in DONE only; err SHALL be 1 in ERR only; both held until next start.
REQ-028 cpu_rst_n SHALL be 0 in LEN0, LEN1, DATA, WRITE, ERR; 1 in IDLE and DONE.
REQ-029 Maximum length 32767 words; word address SHALL never exceed length-1 and SHALL not wrap.
REQ-030 rx_valid without a preceding start SHALL have no effect.

Reset
REQ-031 rst_n=0 at a clock edge SHALL force IDLE, rx_ready=0, flash_we=0, flash_addr=0, flash_din=0, busy=0, done=0, err=0, cpu_rst_n=1; length, index, counters cleared.
REQ-032 Reset asserted mid-session SHALL abort immediately with no further flash write; words already written remain.

Verification
REQ-033 start, bytes 02 00 | 78 56 34 12 | EF BE AD DE -> two WRITE cycles: addr 0 data 0x12345678, addr 1 data 0xDEADBEEF; then done=1, cpu_rst_n=1.
REQ-034 start, bytes 00 00 -> DONE next cycle, no flash_we pulse, done=1.
REQ-035 TIMEOUT=16, start, bytes 01 00 AA, then rx_valid=0 for 16 cycles -> err=1, cpu_rst_n=0, no flash_we; later start re-arms with err=0.
REQ-036 rx_valid held 1 continuously with back-to-back bytes -> rx_ready=0 during each WRITE cycle, no byte lost or duplicated, 5 cycles per word.
REQ-037 rst_n=0 after 2 of 3 words written -> all outputs at reset values next cycle, no third write; start pulsed while busy -> ignored, session continues.

Source files
------------

// File: rtl/flash_loader.sv
// flash_loader: receives a length-prefixed byte stream from a serial receiver
// and programs it, one 32-bit little-endian word at a time, into a flash
// write port while holding the fetching core in reset.
module flash_loader #(
  parameter int ADDR_W  = 15,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] flash_addr,
  output logic [31:0]       flash_din,
  output logic              flash_we,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_rst_n
);

  // Idle counter only needs to reach TIMEOUT-1.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [14:0]       len_q;
  logic [1:0]        byte_idx;
  logic [ADDR_W-1:0] word_addr;
  logic [23:0]       asm_q;
  logic [TW-1:0]     tcnt;

  logic              rx_state;
  logic              accept;
  logic              timeout_hit;
  logic              len_zero;
  logic              last_word;

  // The receive-side handshake depends only on the state register.
  assign rx_state    = (state == LEN0) || (state == LEN1) || (state == DATA);
  assign accept      = rx_valid && rx_state;
  assign timeout_hit = (tcnt == TW'(TIMEOUT - 1));
  // Bit 7 of the high length byte is ignored: lengths are at most 32767 words.
  assign len_zero    = ({rx_data[6:0], len_q[7:0]} == 15'd0);
  assign last_word   = ((32'(word_addr) + 32'd1) == 32'(len_q));

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values regardless of block ordering.
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a signal unassigned, which would infer a latch.
    state_nxt = state;
    rx_ready  = 1'b0;
    flash_we  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    cpu_rst_n = 1'b1;

    case (state)
      IDLE: begin
        if (start) state_nxt = LEN0;
      end

      LEN0: begin
        rx_ready  = 1'b1;
        busy      = 1'b1;
        cpu_rst_n = 1'b0;
        if (accept)           state_nxt = LEN1;
        else if (timeout_hit) state_nxt = ERR;
      end

      LEN1: begin
        rx_ready  = 1'b1;
        busy      = 1'b1;
        cpu_rst_n = 1'b0;
        if (accept)           state_nxt = len_zero ? DONE : DATA;
        else if (timeout_hit) state_nxt = ERR;
      end

      DATA: begin
        rx_ready  = 1'b1;
        busy      = 1'b1;
        cpu_rst_n = 1'b0;
        if (accept) begin
          if (byte_idx == 2'd3) state_nxt = WRITE;
        end else if (timeout_hit) begin
          state_nxt = ERR;
        end
      end

      WRITE: begin
        flash_we  = 1'b1;
        busy      = 1'b1;
        cpu_rst_n = 1'b0;
        state_nxt = last_word ? DONE : DATA;
      end

      DONE: begin
        done = 1'b1;
        if (start) state_nxt = LEN0;
      end

      ERR: begin
        err       = 1'b1;
        cpu_rst_n = 1'b0;
        if (start) state_nxt = LEN0;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: length capture, word assembly, address and idle counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q      <= '0;
      byte_idx   <= '0;
      word_addr  <= '0;
      asm_q      <= '0;
      tcnt       <= '0;
      flash_addr <= '0;
      flash_din  <= '0;
    end else begin
      // Idle counter: runs only while waiting for bytes, cleared by each byte,
      // untouched in WRITE and in the terminal states.
      if (rx_state) begin
        if (accept) tcnt <= '0;
        else        tcnt <= tcnt + 1'b1;
      end

      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            len_q     <= '0;
            byte_idx  <= '0;
            word_addr <= '0;
            tcnt      <= '0;
          end
        end

        LEN0: begin
          if (accept) len_q[7:0] <= rx_data;
        end

        LEN1: begin
          if (accept) begin
            len_q[14:8] <= rx_data[6:0];
            byte_idx    <= '0;
          end
        end

        DATA: begin
          if (accept) begin
            byte_idx <= byte_idx + 1'b1;
            case (byte_idx)
              2'd0: asm_q[7:0]   <= rx_data;
              2'd1: asm_q[15:8]  <= rx_data;
              2'd2: asm_q[23:16] <= rx_data;
              default: begin
                // Word complete: present it on the write port for WRITE.
                flash_din  <= {rx_data, asm_q};
                flash_addr <= word_addr;
              end
            endcase
          end
        end

        WRITE: begin
          // The final word leaves the address at length-1 rather than wrapping.
          if (!last_word) word_addr <= word_addr + 1'b1;
        end

        default: ;
      endcase
    end
  end

endmodule
